// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built purely from two-input NAND gates (nine-gate form).
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic n1, n2, n3, x1, n4, n5, n6;

    // First half-adder: x1 = a ^ b; n1 doubles as the (a & b) carry term.
    assign n1 = ~(a & b);
    assign n2 = ~(a & n1);
    assign n3 = ~(b & n1);
    assign x1 = ~(n2 & n3);

    assign n4 = ~(x1 & ci);
    assign n5 = ~(x1 & n4);
    assign n6 = ~(ci & n4);
    assign s  = ~(n5 & n6);
    assign co = ~(n4 & n1);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    serial_fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases and random operands at WIDTH=8,
// plus an exhaustive sweep of a WIDTH=4 instance, all checked against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endfunction

    // Reference model: {cout,sum} is simply the unsigned sum.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Signed overflow: carry into the MSB differs from carry out of it.
    function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int ci_msb;
        int co_msb;
        ci_msb = (int'(x & 8'h7F) + int'(y & 8'h7F) + int'(c)) >> 7;
        co_msb = (int'(x) + int'(y) + int'(c)) >> 8;
        return 1'(ci_msb ^ co_msb);
    endfunction

    // Called at the negedge just after the accepting edge; returns edges elapsed until done.
    task automatic wait_done8(input string tag, output int lat);
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            check({tag, "_busy"}, 32'(busy8), 32'd1);
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 32'(done8), 32'd1);
    endtask

    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic [8:0] exp);
        int lat;
        @(negedge clk);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        wait_done8(tag, lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_result"}, 32'({cout8, sum8}), 32'(exp));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf8), 32'(ref_ovf8(x, y, c)));
`endif
        $display("op %s: a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h latency=%0d",
                 tag, x, y, c, cout8, sum8, lat);
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int lat;
        @(negedge clk);
        a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~x; b4 = ~y; cin4 = ~c;
        lat = 0;
        while (done4 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("w4_latency", 32'(lat), 32'd4);
        check("w4_result", 32'({cout4, sum4}), 32'(int'(x) + int'(y) + int'(c)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         dones;
        int         dlat;
        logic [8:0] dres;
        logic [7:0] rx, ry;
        logic       rc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf8), 32'd0);
`endif
        $display("reset: busy=%0d done=%0d sum=%02h cout=%0d", busy8, done8, sum8, cout8);
        rst = 1'b0;

        // Directed arithmetic
        run8("basic", 8'h5A, 8'h33, 1'b0, 9'h08D);
        check("basic_hold_after", 32'({busy8, done8}), 32'd1);
        @(negedge clk);
        check("basic_idle_busy", 32'({busy8, done8}), 32'd0);
        check("basic_sum_held", 32'(sum8), 32'h8D);
        run8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
        run8("ovf_pos", 8'h7F, 8'h01, 1'b0, 9'h080);
        run8("max", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run8("zero", 8'h00, 8'h00, 1'b0, 9'h000);
        run8("cin_only", 8'h00, 8'h00, 1'b1, 9'h001);

        // Start while busy is ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 3; dones = 0; dlat = 0; dres = '0;
        while (lat < 14) begin
            if (done8 === 1'b1) begin
                dones++;
                dlat = lat;
                dres = {cout8, sum8};
            end
            @(negedge clk);
            lat++;
        end
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_latency", 32'(dlat), 32'd8);
        check("busy_start_result", 32'(dres), 32'h030);
        check("busy_start_held", 32'(sum8), 32'h30);
        $display("start-while-busy: dones=%0d latency=%0d result=%03h", dones, dlat, dres);

        // Back-to-back: start during DONE
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("b2b_first", lat);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_result", 32'({cout8, sum8}), 32'h047);
        a8 = 8'hC0; b8 = 8'h81; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_restart_state", 32'({busy8, done8}), 32'd2);
        check("b2b_restart_clear", 32'({cout8, sum8}), 32'd0);
        wait_done8("b2b_second", dlat);
        check("b2b_total_latency", 32'(lat + 1 + dlat), 32'd17);
        check("b2b_second_result", 32'({cout8, sum8}), 32'h141);
        @(negedge clk);
        check("b2b_idle", 32'({busy8, done8}), 32'd0);
        $display("back-to-back: second done at k+%0d result=%03h", lat + 1 + dlat, {cout8, sum8});

        // Reset mid-operation, then start right at release
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_sum", 32'(sum8), 32'd0);
        check("midrst_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        a8 = 8'h9C; b8 = 8'h77; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("after_rst", lat);
        check("after_rst_latency", 32'(lat), 32'd8);
        check("after_rst_result", 32'({cout8, sum8}), 32'h114);
        $display("reset-abort: restart latency=%0d result=%03h", lat, {cout8, sum8});

        // Reset wins over start
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        check("rst_priority_busy", 32'(busy8), 32'd0);
        rst = 1'b0; start8 = 1'b0;
        $display("reset-priority: busy=%0d", busy8);

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            run8("rand", rx, ry, rc, ref_add8(rx, ry, rc));
        end

        // Exhaustive 4-bit sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    run4(4'(x), 4'(y), 1'(c));
                end
            end
            $display("w4 sweep: a=%0d done, checks so far %0d", x, total);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
